fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the RV32I core, directly upstream of the control unit. It owns the program counter and issues one word-aligned request at a time to instruction memory over a valid/ready handshake. It buffers the returned word, then presents it with its PC to the decode stage, where `op` = instr[6:0] feeds the main decoder. It accepts redirects (taken branch, jal, jalr) from execute, discarding wrong-path instructions, including in-flight memory responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_addr`  out  32  request address, bits [1:0] always 0
- `imem_rsp_valid`  in  1  response word valid (one cycle pulse, cannot be stalled)
- `imem_rsp_data`  in  32  instruction word
- `redirect`  in  1  flush and restart fetch at `redirect_pc`
- `redirect_pc`  in  32  target; bits [1:0] ignored (treated as 0)
- `id_ready`  in  1  decode accepts `id_*` this cycle
- `id_valid`  out  1  `id_*` holds a valid instruction
- `id_instr`  out  32  instruction to decode
- `id_pc`  out  32  address of `id_instr`
- `id_pc_plus4`  out  32  `id_pc` + 4, modulo 2^32

## Operation
- Requests: `pc` register; `imem_addr` = {pc[31:2],2'b00}.
- At most one outstanding request.
- Responses return ≥1 cycle after acceptance, in order.
- FSM states:
  - REQ: `imem_req_valid`=1.
    - Accept (valid & ready, no redirect) → WAIT.
    - Accept with redirect in the same cycle → DROP.
    - Redirect without accept → stay REQ at the new pc.
  - WAIT: awaiting the response.
    - Response, output slot free → load `id_*`, pc += 4, → REQ.
    - Response, slot busy → write buffer, pc += 4, → HOLD.
    - Redirect (with or without response) → response discarded. Go to REQ if the response arrived this cycle, else DROP.
  - HOLD: buffer full, no request issued.
    - Slot frees → buffer moves to `id_*`, → REQ.
    - Redirect → buffer discarded, → REQ.
  - DROP: killed request in flight, no request issued.
    - Response → discarded, → REQ.
    - Redirect → pc updated; stay DROP unless a response arrives the same cycle, in which case → REQ.
- Output slot free ⇔ `!id_valid || id_ready`.
- Redirect has priority over every other event:
  - pc ← {redirect_pc[31:2],2'b00}.
  - `id_valid` ← 0 next edge regardless of `id_ready`.
- `id_*` hold stable while `id_valid && !id_ready`.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset (asynchronous, immediate):
  - State = REQ, pc = `RESET_PC`.
  - `id_valid`=0, `id_instr`=32'h0000_0013 (NOP), `id_pc`=0, `id_pc_plus4`=4.
  - Buffer cleared.
- `imem_req_valid` is 0 while `rst` is high. It is 1 in the first cycle after release.
- Reset mid-transaction: any pending response is ignored because state is REQ. Memory is reset by the same `rst`.
- Best-case latency: request accepted cycle N, response cycle N+1, `id_valid`=1 cycle N+2. Throughput is 1 instruction per 2 cycles with single-cycle memory.
- `imem_addr` stable while `imem_req_valid && !imem_req_ready`, unless a redirect occurs.
- Redirect asserted cycle N: `id_valid`=0 in N+1; new address presented in N+1 if state becomes REQ.

## Structure
- `fetch_pkg`:
  - `fetch_state_t` enum {REQ, WAIT, HOLD, DROP}.
  - `NOP_INSTR` = 32'h0000_0013.
  - `PC_STEP` = 32'd4.
- One sub-module: `fetch_buffer`, a one-entry instr/pc holding register with load/clear/full. Used in HOLD.
- FSM, pc register and `id_*` register live in `fetch_stage`.

## Test plan
- Reset with `RESET_PC`=32'h100, memory always ready, 1-cycle response returning 32'h00500093 at 0x100: `imem_addr`=0x100 first cycle. `id_instr`=32'h00500093, `id_pc`=0x100, `id_pc_plus4`=0x104 two cycles later. Next request at 0x104.
- `id_ready` held 0 for 5 cycles after the first instruction: second response lands in the buffer. No third request while in HOLD. `id_*` stable. The second word appears the cycle after `id_ready`=1.
- Redirect to 0x200 in WAIT with the response 3 cycles later: response discarded. Next `imem_addr`=0x200. No instruction from the old path ever has `id_valid`=1.
- Redirect coincident with a response: response discarded. Request to the target issued next cycle.
- Redirect to 0x203: `imem_addr`=0x200.
- Redirect to 32'hFFFF_FFFC: the following fetch address is 0x0.
- `rst` pulsed during WAIT and during HOLD: outputs immediately take their reset values. A late `imem_rsp_valid` is ignored. Fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect, decode handoff.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// One-entry holding register for a fetched word that decode could not yet accept.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         full
);

  fetch_entry_t entry_q, entry_d;
  logic         full_q, full_d;

  // Load wins over clear so a same-cycle refill never loses data.
  always_comb begin
    entry_d = entry_q;
    full_d  = full_q;
    if (clear) full_d = 1'b0;
    if (load) begin
      entry_d = load_entry;
      full_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '{instr: NOP_INSTR, pc: '0};
      full_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      full_q  <= full_d;
    end
  end

  assign entry = entry_q;
  assign full  = full_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, issues one imem request at a time,
// hands words to decode and squashes wrong-path fetches on redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;

  logic            req_valid;
  logic            accept;
  logic            slot_free;
  logic            buf_load, buf_clear, buf_full;
  fetch_entry_t    buf_entry;
  logic [XLEN-1:0] redirect_target;

  // Request is a decode of REQ, masked while reset is held.
  assign req_valid       = (state_q == REQ) && !rst;
  assign accept          = req_valid && bus.imem_req_ready;
  assign slot_free       = !id_valid_q || bus.id_ready;
  assign redirect_target = word_align(bus.redirect_pc);

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_entry ('{instr: bus.imem_rsp_data, pc: pc_q}),
    .entry      (buf_entry),
    .full       (buf_full)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q && !bus.id_ready;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;

    unique case (state_q)
      REQ: begin
        if (bus.redirect) begin
          pc_d    = redirect_target;
          state_d = accept ? DROP : REQ;
        end else if (accept) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          pc_d    = redirect_target;
          state_d = bus.imem_rsp_valid ? REQ : DROP;
        end else if (bus.imem_rsp_valid) begin
          pc_d = pc_q + PC_STEP;
          if (slot_free) begin
            id_valid_d    = 1'b1;
            id_instr_d    = bus.imem_rsp_data;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_q + PC_STEP;
            state_d       = REQ;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.redirect) begin
          pc_d      = redirect_target;
          buf_clear = 1'b1;
          state_d   = REQ;
        end else if (slot_free && buf_full) begin
          id_valid_d    = 1'b1;
          id_instr_d    = buf_entry.instr;
          id_pc_d       = buf_entry.pc;
          id_pc_plus4_d = buf_entry.pc + PC_STEP;
          buf_clear     = 1'b1;
          state_d       = REQ;
        end
      end
      DROP: begin
        if (bus.redirect) pc_d = redirect_target;
        if (bus.imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    // A redirect always empties the decode slot on the next edge.
    if (bus.redirect) id_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= REQ;
      pc_q          <= word_align(RESET_PC);
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= '0;
      id_pc_plus4_q <= PC_STEP;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_instr       = id_instr_q;
  assign bus.id_pc          = id_pc_q;
  assign bus.id_pc_plus4    = id_pc_plus4_q;

endmodule
